// File: rtl/mpeg_bits_pkg.sv
// Shared types and sizing for the MPEG bitstream read front end.
package mpeg_bits_pkg;

  localparam int unsigned GB_WIN_W   = 32;
  localparam int unsigned GB_MAX_N   = 32;
  localparam int unsigned GB_TIMEOUT = 15;
  localparam int unsigned GB_REQ_W   = 6;
  localparam int unsigned GB_TO_W    = 4;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    READY = 2'd3
  } gb_state_e;

endpackage

// File: rtl/getbits_unit.sv
// Get/show N-bit requests against the flushbuffer window.
// Consuming reads drive the flush handshake and recapture the refreshed window.
module getbits_unit
  import mpeg_bits_pkg::*;
#(
  parameter int unsigned MAX_N   = GB_MAX_N,
  parameter int unsigned TIMEOUT = GB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [GB_REQ_W-1:0] req_n,
  input  logic                req_show,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [GB_WIN_W-1:0] rsp_data,
  output logic                rsp_err,
  output logic [31:0]         fb_N,
  output logic                fb_in_valid,
  input  logic                fb_loading,
  input  logic                fb_done,
  input  logic [GB_WIN_W-1:0] fb_ld_bfr,
  input  logic [31:0]         fb_incnt,
  output logic [31:0]         bits_consumed,
  output logic                fb_timeout
);

  gb_state_e           state, state_nxt;
  logic [GB_WIN_W-1:0] window, window_nxt;
  logic [GB_TO_W-1:0]  to_cnt, to_cnt_nxt;

  logic                req_ready_nxt;
  logic                rsp_valid_nxt;
  logic [GB_WIN_W-1:0] rsp_data_nxt;
  logic                rsp_err_nxt;
  logic [31:0]         fb_N_nxt;
  logic                fb_in_valid_nxt;
  logic [31:0]         bits_nxt;
  logic                fb_timeout_nxt;

  logic                accept_c;
  logic                req_bad_c;
  logic [GB_WIN_W-1:0] extract_c;

  // fb_incnt is a debug-only observation; it never steers control
  logic                unused_incnt;
  assign unused_incnt = ^fb_incnt;

  assign accept_c  = req_valid && req_ready;
  assign req_bad_c = (req_n == '0) || (32'(req_n) > MAX_N);
  assign extract_c = window >> (GB_REQ_W'(GB_WIN_W) - req_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= PRIME;
      window        <= '0;
      to_cnt        <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      fb_N          <= '0;
      fb_in_valid   <= 1'b0;
      bits_consumed <= '0;
      fb_timeout    <= 1'b0;
    end else begin
      state         <= state_nxt;
      window        <= window_nxt;
      to_cnt        <= to_cnt_nxt;
      req_ready     <= req_ready_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_data      <= rsp_data_nxt;
      rsp_err       <= rsp_err_nxt;
      fb_N          <= fb_N_nxt;
      fb_in_valid   <= fb_in_valid_nxt;
      bits_consumed <= bits_nxt;
      fb_timeout    <= fb_timeout_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    window_nxt      = window;
    to_cnt_nxt      = '0;
    rsp_valid_nxt   = 1'b0;
    rsp_data_nxt    = rsp_data;
    rsp_err_nxt     = rsp_err;
    fb_N_nxt        = fb_N;
    fb_in_valid_nxt = 1'b0;
    bits_nxt        = bits_consumed;
    fb_timeout_nxt  = fb_timeout;

    case (state)
      PRIME: begin
        fb_N_nxt        = '0;
        fb_in_valid_nxt = 1'b1;
        state_nxt       = ISSUE;
      end
      ISSUE: begin
        to_cnt_nxt = to_cnt + GB_TO_W'(1);
        if (fb_loading) begin
          state_nxt = WAIT;
        end else if (32'(to_cnt_nxt) >= TIMEOUT) begin
          fb_timeout_nxt = 1'b1;
          state_nxt      = READY;
        end
      end
      WAIT: begin
        // done is a level; only trusted once loading has been seen for this flush
        if (!fb_loading && fb_done) begin
          window_nxt = fb_ld_bfr;
          state_nxt  = READY;
        end
      end
      READY: begin
        if (accept_c) begin
          rsp_valid_nxt = 1'b1;
          if (req_bad_c) begin
            rsp_data_nxt = '0;
            rsp_err_nxt  = 1'b1;
          end else begin
            rsp_data_nxt = extract_c;
            rsp_err_nxt  = 1'b0;
            if (!req_show) begin
              fb_N_nxt        = 32'(req_n);
              fb_in_valid_nxt = 1'b1;
              bits_nxt        = bits_consumed + 32'(req_n);
              state_nxt       = ISSUE;
            end
          end
        end
      end
      default: state_nxt = PRIME;
    endcase

    req_ready_nxt = (state_nxt == READY);
  end

endmodule
